// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, frame limits, FSM state encoding
// and a data-bit clamp used when a frame's configuration is latched.
package uart_pkg;

    localparam logic [2:0] PARITY_NONE  = 3'd0;
    localparam logic [2:0] PARITY_EVEN  = 3'd1;
    localparam logic [2:0] PARITY_ODD   = 3'd2;
    localparam logic [2:0] PARITY_MARK  = 3'd3;
    localparam logic [2:0] PARITY_SPACE = 3'd4;

    localparam int UART_MIN_DATA_BITS = 5;
    localparam int PRESCALE_MULT      = 8;
    localparam int BIT_TIMER_W        = 19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    // Force the requested data-bit count into [UART_MIN_DATA_BITS, max_bits].
    function automatic logic [4:0] clamp_data_bits(input logic [4:0] req,
                                                   input int unsigned max_bits);
        if (req < 5'(UART_MIN_DATA_BITS)) return 5'(UART_MIN_DATA_BITS);
        if (32'(req) > max_bits) return 5'(max_bits);
        return req;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Stream handshake carrying one payload word per frame into the transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter: tick is high in the last cycle of a bit period.
// A load of N-1 therefore yields a period of exactly N cycles.
module uart_bit_timer #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tick
);
    logic [W-1:0] cnt;

    // Reload at each bit start, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst)              cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign tick = (cnt == '0);
endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame data width, parity and stop-bit count.
// Frame format and prescale are captured at accept, so config changes
// mid-frame only affect the next frame.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    uart_tx_cfg_if.slave input_axi,
    output logic        txd,
    output logic        busy,
    input  logic [15:0] prescale,
    input  logic [4:0]  cfg_data_bits,
    input  logic [2:0]  cfg_parity,
    input  logic        cfg_stop_bits
);
    uart_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]  data_q, data_d, data_in;
    logic [4:0]             dbits_q, dbits_in;
    logic [4:0]             idx_q, idx_d;
    logic [BIT_TIMER_W-1:0] period_q, period_in, load_val;
    logic [15:0]            psc_in;
    logic par_en_q, par_en_in, par_bit_q, par_bit_in;
    logic stop2_q, stop_left_q, stop_left_d;
    logic txd_q, txd_d;
    logic ready_en_q;
    logic tick, load, frame_end, tready, accept;

    uart_bit_timer #(.W(BIT_TIMER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tick     (tick)
    );

    // Sanitise the incoming frame configuration before it is latched.
    always_comb begin
        dbits_in = clamp_data_bits(cfg_data_bits, DATA_WIDTH);
        for (int i = 0; i < DATA_WIDTH; i++)
            data_in[i] = input_axi.tdata[i] & (i < int'(dbits_in));
        psc_in    = (prescale == 16'd0) ? 16'd1 : prescale;
        period_in = BIT_TIMER_W'(psc_in) * BIT_TIMER_W'(PRESCALE_MULT) - 1'b1;
        par_en_in = (cfg_parity >= PARITY_EVEN) && (cfg_parity <= PARITY_SPACE);
        case (cfg_parity)
            PARITY_EVEN: par_bit_in = ^data_in;
            PARITY_ODD:  par_bit_in = ~^data_in;
            PARITY_MARK: par_bit_in = 1'b1;
            default:     par_bit_in = 1'b0;
        endcase
    end

    // Next-state, next-txd and timer control. Ready also opens in the final
    // cycle of the last stop bit so a waiting word starts with no idle gap.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        idx_d       = idx_q;
        stop_left_d = stop_left_q;
        txd_d       = txd_q;
        load        = 1'b0;
        load_val    = period_q;
        frame_end   = 1'b0;
        case (state_q)
            ST_IDLE: txd_d = 1'b1;
            ST_START: if (tick) begin
                state_d = ST_DATA;
                txd_d   = data_q[0];
                data_d  = data_q >> 1;
                idx_d   = '0;
                load    = 1'b1;
            end
            ST_DATA: if (tick) begin
                load = 1'b1;
                if (idx_q == dbits_q - 5'd1) begin
                    if (par_en_q) begin
                        state_d = ST_PARITY;
                        txd_d   = par_bit_q;
                    end else begin
                        state_d     = ST_STOP;
                        txd_d       = 1'b1;
                        stop_left_d = stop2_q;
                    end
                end else begin
                    idx_d  = idx_q + 5'd1;
                    txd_d  = data_q[0];
                    data_d = data_q >> 1;
                end
            end
            ST_PARITY: if (tick) begin
                state_d     = ST_STOP;
                txd_d       = 1'b1;
                stop_left_d = stop2_q;
                load        = 1'b1;
            end
            ST_STOP: if (tick) begin
                if (stop_left_q) begin
                    stop_left_d = 1'b0;
                    load        = 1'b1;
                end else begin
                    frame_end = 1'b1;
                    state_d   = ST_IDLE;
                    txd_d     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tready = ready_en_q && ((state_q == ST_IDLE) || frame_end);
        accept = input_axi.tvalid && tready;
        if (accept) begin
            state_d  = ST_START;
            txd_d    = 1'b0;
            load     = 1'b1;
            load_val = period_in;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Datapath: line driver, bit index, stop count and latched frame config.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd_q       <= 1'b1;
            ready_en_q  <= 1'b0;
            idx_q       <= '0;
            stop_left_q <= 1'b0;
            data_q      <= '0;
            dbits_q     <= '0;
            period_q    <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
        end else begin
            txd_q       <= txd_d;
            ready_en_q  <= 1'b1;
            idx_q       <= idx_d;
            stop_left_q <= stop_left_d;
            if (accept) begin
                data_q    <= data_in;
                dbits_q   <= dbits_in;
                period_q  <= period_in;
                par_en_q  <= par_en_in;
                par_bit_q <= par_bit_in;
                stop2_q   <= cfg_stop_bits;
            end else begin
                data_q    <= data_d;
            end
        end
    end

    assign input_axi.tready = tready;
    assign txd  = txd_q;
    assign busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: each frame is captured cycle by cycle
// from the accept edge and compared bit-period by bit-period against
// hand-built expected frames {stop, parity, data, start}.
module tb_uart_tx_cfg;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        txd, busy;
    logic [15:0] prescale;
    logic [4:0]  cfg_data_bits;
    logic [2:0]  cfg_parity;
    logic        cfg_stop_bits;

    int checks = 0;
    int errors = 0;

    logic txd_log  [0:511];
    logic busy_log [0:511];

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_WIDTH(DW)) axi ();

    uart_tx_cfg #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .input_axi     (axi),
        .txd           (txd),
        .busy          (busy),
        .prescale      (prescale),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop_bits (cfg_stop_bits)
    );

    // Present a word and return at the negedge of cycle 0 (just after accept).
    task automatic start_frame(input logic [7:0] d, input logic [15:0] psc,
                               input logic [4:0] nb, input logic [2:0] par,
                               input logic st, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        axi.tdata = d; axi.tvalid = 1'b1;
        prescale = psc; cfg_data_bits = nb; cfg_parity = par; cfg_stop_bits = st;
        while (!axi.tready && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (!axi.tready) begin
            errors++;
            $display("FAIL start_timeout tready=%b expected 1", axi.tready);
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) axi.tvalid = 1'b0;
    endtask

    // Record n cycles into the logs starting at index base.
    task automatic capture(input int base, input int n);
        for (int c = base; c < base + n; c++) begin
            txd_log[c]  = txd;
            busy_log[c] = busy;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; axi.tvalid = 1'b1; axi.tdata = 8'hAA;
        repeat (3) @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL rst_txd got %b expected 1", txd); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_with_tvalid got %b expected 0", busy); end
        checks++;
        if (axi.tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b expected 0", axi.tready); end
        axi.tvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready got %b expected 1", axi.tready); end
        checks++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL post_rst_idle txd=%b busy=%b expected 1/0", txd, busy);
        end
    endtask

    task automatic test_8n1();
        logic [15:0] exp;
        exp = 16'({1'b1, 8'h55, 1'b0});
        start_frame(8'h55, 16'd1, 5'd8, 3'd0, 1'b0, 1'b0);
        capture(0, 80);
        for (int b = 0; b < 10; b++) begin
            int bad;
            bad = -1;
            for (int c = b*8; c < (b+1)*8; c++) if (bad < 0 && txd_log[c] !== exp[b]) bad = c;
            checks++;
            if (bad >= 0) begin errors++; $display("FAIL 8n1_bit%0d cycle %0d txd=%b expected %b", b, bad, txd_log[bad], exp[b]); end
        end
        for (int c = 0; c < 80; c++) if (busy_log[c] !== 1'b1) begin
            errors++; $display("FAIL 8n1_busy cycle %0d got %b expected 1", c, busy_log[c]); break;
        end
        checks++;
        checks++;
        if (busy !== 1'b0 || axi.tready !== 1'b1) begin
            errors++; $display("FAIL 8n1_end cycle 80 busy=%b tready=%b expected 0/1", busy, axi.tready);
        end
    endtask

    task automatic test_7e1();
        logic [15:0] exp;
        // 0xC1 truncated to 7 bits = 0x41 (two ones) -> even parity 0
        exp = 16'({1'b1, 1'b0, 7'h41, 1'b0});
        start_frame(8'hC1, 16'd1, 5'd7, 3'd1, 1'b0, 1'b0);
        capture(0, 80);
        for (int b = 0; b < 10; b++) begin
            int bad;
            bad = -1;
            for (int c = b*8; c < (b+1)*8; c++) if (bad < 0 && txd_log[c] !== exp[b]) bad = c;
            checks++;
            if (bad >= 0) begin errors++; $display("FAIL 7e1_bit%0d cycle %0d txd=%b expected %b", b, bad, txd_log[bad], exp[b]); end
        end
        checks++;
        if (busy_log[79] !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL 7e1_len busy@79=%b busy@80=%b expected 1/0", busy_log[79], busy);
        end
    endtask

    task automatic test_8o2();
        logic [15:0] exp;
        // eight ones: XOR = 0, odd parity bit is its inverse = 1
        exp = 16'({2'b11, 1'b1, 8'hFF, 1'b0});
        start_frame(8'hFF, 16'd2, 5'd8, 3'd2, 1'b1, 1'b0);
        capture(0, 192);
        for (int b = 0; b < 12; b++) begin
            int bad;
            bad = -1;
            for (int c = b*16; c < (b+1)*16; c++) if (bad < 0 && txd_log[c] !== exp[b]) bad = c;
            checks++;
            if (bad >= 0) begin errors++; $display("FAIL 8o2_bit%0d cycle %0d txd=%b expected %b", b, bad, txd_log[bad], exp[b]); end
        end
        checks++;
        if (busy_log[191] !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL 8o2_len busy@191=%b busy@192=%b expected 1/0", busy_log[191], busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        exp = {12'd0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
        start_frame(8'hA5, 16'd1, 5'd8, 3'd0, 1'b0, 1'b1);
        axi.tdata = 8'h3C;
        capture(0, 80);
        axi.tvalid = 1'b0;
        capture(80, 80);
        for (int b = 0; b < 20; b++) begin
            int bad;
            bad = -1;
            for (int c = b*8; c < (b+1)*8; c++) if (bad < 0 && txd_log[c] !== exp[b]) bad = c;
            checks++;
            if (bad >= 0) begin errors++; $display("FAIL b2b_bit%0d cycle %0d txd=%b expected %b", b, bad, txd_log[bad], exp[b]); end
        end
        for (int c = 0; c < 160; c++) if (busy_log[c] !== 1'b1) begin
            errors++; $display("FAIL b2b_busy_gap cycle %0d got %b expected 1", c, busy_log[c]); break;
        end
        checks++;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end busy@160 got %b expected 0", busy); end
    endtask

    task automatic test_clamp_low();
        logic [15:0] exp;
        // prescale 0 -> 1; 3 data bits -> 5; 0xFB low five bits = 11011
        exp = 16'({1'b1, 5'b11011, 1'b0});
        start_frame(8'hFB, 16'd0, 5'd3, 3'd0, 1'b0, 1'b0);
        capture(0, 20);
        cfg_parity = 3'd3; cfg_data_bits = 5'd8; cfg_stop_bits = 1'b1; prescale = 16'd4;
        capture(20, 36);
        for (int b = 0; b < 7; b++) begin
            int bad;
            bad = -1;
            for (int c = b*8; c < (b+1)*8; c++) if (bad < 0 && txd_log[c] !== exp[b]) bad = c;
            checks++;
            if (bad >= 0) begin errors++; $display("FAIL clamp_bit%0d cycle %0d txd=%b expected %b", b, bad, txd_log[bad], exp[b]); end
        end
        checks++;
        if (busy_log[55] !== 1'b1 || busy !== 1'b0 || axi.tready !== 1'b1) begin
            errors++; $display("FAIL clamp_len busy@55=%b busy@56=%b tready=%b expected 1/0/1", busy_log[55], busy, axi.tready);
        end
    endtask

    task automatic test_clamp_high();
        logic [15:0] exp;
        // 31 data bits -> 8; space parity = 0
        exp = 16'({1'b1, 1'b0, 8'h81, 1'b0});
        start_frame(8'h81, 16'd1, 5'd31, 3'd4, 1'b0, 1'b0);
        capture(0, 88);
        for (int b = 0; b < 11; b++) begin
            int bad;
            bad = -1;
            for (int c = b*8; c < (b+1)*8; c++) if (bad < 0 && txd_log[c] !== exp[b]) bad = c;
            checks++;
            if (bad >= 0) begin errors++; $display("FAIL clamp_hi_bit%0d cycle %0d txd=%b expected %b", b, bad, txd_log[bad], exp[b]); end
        end
        checks++;
        if (busy_log[87] !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL clamp_hi_len busy@87=%b busy@88=%b expected 1/0", busy_log[87], busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] exp;
        start_frame(8'h07, 16'd1, 5'd8, 3'd0, 1'b0, 1'b0);
        capture(0, 34);
        checks++;
        if (txd_log[33] !== 1'b0 || busy_log[33] !== 1'b1) begin
            errors++; $display("FAIL mid_pre data3 txd=%b busy=%b expected 0/1", txd_log[33], busy_log[33]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL mid_rst_txd got %b expected 1", txd); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b expected 0", busy); end
        checks++;
        if (axi.tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready got %b expected 0", axi.tready); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.tready !== 1'b1) begin errors++; $display("FAIL mid_rel_tready got %b expected 1", axi.tready); end
        exp = 16'({1'b1, 8'h96, 1'b0});
        start_frame(8'h96, 16'd1, 5'd8, 3'd0, 1'b0, 1'b0);
        capture(0, 80);
        for (int b = 0; b < 10; b++) begin
            int bad;
            bad = -1;
            for (int c = b*8; c < (b+1)*8; c++) if (bad < 0 && txd_log[c] !== exp[b]) bad = c;
            checks++;
            if (bad >= 0) begin errors++; $display("FAIL mid_next_bit%0d cycle %0d txd=%b expected %b", b, bad, txd_log[bad], exp[b]); end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_next_end busy got %b expected 0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        axi.tdata = '0; axi.tvalid = 1'b0;
        prescale = 16'd1; cfg_data_bits = 5'd8; cfg_parity = 3'd0; cfg_stop_bits = 1'b0;
        test_reset();
        test_8n1();
        test_7e1();
        test_8o2();
        test_back_to_back();
        test_clamp_low();
        test_clamp_high();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
